instr_mem_pipe: RTL and testbench
=================================

INSTR_MEM_PIPE -- requirements
Module: instr_mem_pipe

Interface
REQ-001 Parameter ID, default 0, instance identifier; no effect on behaviour.
REQ-002 Parameter DEPTH, default 128, words of storage; power of two, >= 4.
REQ-003 Parameter LATENCY, default 1, cycles from grant to response; legal 1..4.
REQ-004 Parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0; DEPTH*4-aligned.
REQ-005 Parameter NO_OP, default 32'h0000_0013, fill and default instruction word.
REQ-006 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-007 rst_ni  in  1  reset, asynchronous, active-low.
REQ-008 enable_i  in  1  fetch enable, sampled at request acceptance.
REQ-009 instr_req_i  in  1  fetch request.
REQ-010 instr_addr_i  in  32  fetch byte address.
REQ-011 instr_gnt_o  out  1  request accepted this cycle.
REQ-012 instr_rvalid_o  out  1  response valid this cycle.
REQ-013 instr_rdata_o  out  32  fetched instruction.
REQ-014 instr_err_o  out  1  fetch error, qualified by instr_rvalid_o.
REQ-015 load_we_i  in  1  program-load write strobe.
REQ-016 load_addr_i  in  $clog2(DEPTH)  program-load word index.
REQ-017 load_data_i  in  32  program-load data.
REQ-018 busy_o  out  1  high while the block is initialising.

Function
REQ-019 FSM states: INIT, RUN; no other states.
REQ-020 INIT: internal counter walks index 0..DEPTH-1, writing NO_OP to one word per cycle; exactly DEPTH cycles, then RUN.
REQ-021 RUN is held until reset; busy_o = (state == INIT).
REQ-022 load_we_i in INIT is ignored; in RUN, writes load_data_i to mem[load_addr_i] at the clock edge.
REQ-023 instr_gnt_o = instr_req_i AND state==RUN AND NOT load_we_i (combinational); load has priority over fetch.
REQ-024 Accepted = instr_req_i AND instr_gnt_o; index = (instr_addr_i - BASE_ADDR) >> 2, 32-bit unsigned arithmetic.
REQ-025 In range = instr_addr_i >= BASE_ADDR AND index < DEPTH AND instr_addr_i[1:0] == 0.
REQ-026 Response word determined at acceptance: enable_i=0 -> NO_OP, err 0; else out of range -> NO_OP, err 1; else mem[index], err 0.
REQ-027 instr_rvalid_o is high for exactly one cycle, exactly LATENCY cycles after the acceptance edge; responses return in order.
REQ-028 Acceptance is allowed every RUN cycle; pipeline holds up to LATENCY in-flight responses with no stall.
REQ-029 A load to a word after its fetch was accepted does not alter that in-flight response.
REQ-030 When instr_rvalid_o=0: instr_rdata_o = NO_OP, instr_err_o = 0.
REQ-031 Requests issued while instr_gnt_o=0 are not queued; the requester holds or retries.

Reset
REQ-032 While rst_ni=0: instr_gnt_o=0, instr_rvalid_o=0, instr_rdata_o=NO_OP, instr_err_o=0, busy_o=1, state=INIT, counter=0.
REQ-033 Reset asserted mid-operation discards all in-flight responses immediately; no rvalid follows.
REQ-034 After reset release, INIT reruns; previously loaded contents are overwritten with NO_OP.

Verification
REQ-035 Reset release, DEPTH=128 -> busy_o=1 for 128 cycles, gnt=0 throughout; fetch 0x7C after INIT -> rdata 0x0000_0013, err 0.
REQ-036 LATENCY=3; load mem[5]=0xDEAD_BEEF; fetch 0x14 -> rvalid exactly 3 cycles after gnt, rdata 0xDEAD_BEEF.
REQ-037 Back-to-back fetches 0x0, 0x4, 0x8 on consecutive cycles, LATENCY=2 -> three consecutive rvalid cycles, in order, data matching loaded words.
REQ-038 Fetch 0x200 (DEPTH=128) and fetch 0x6 -> rdata 0x0000_0013, err 1; fetch with enable_i=0 -> NO_OP, err 0.
REQ-039 req and load_we_i same cycle -> gnt=0, write committed; req held -> gnt next cycle, rdata = new value.
REQ-040 rst_ni pulsed low with 2 responses in flight -> rvalid stays 0, busy_o=1, INIT reruns for DEPTH cycles.

Source files
------------

// File: rtl/instr_mem_pipe.sv
// Instruction memory: NO_OP fill sweep after reset, program-load write port,
// and a fixed-latency, in-order, non-stalling fetch response pipeline.
module instr_mem_pipe #(
  parameter int unsigned ID        = 0,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NO_OP     = 32'h0000_0013
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic                     instr_req_i,
  input  logic [31:0]              instr_addr_i,
  output logic                     instr_gnt_o,
  output logic                     instr_rvalid_o,
  output logic [31:0]              instr_rdata_o,
  output logic                     instr_err_o,
  input  logic                     load_we_i,
  input  logic [$clog2(DEPTH)-1:0] load_addr_i,
  input  logic [31:0]              load_data_i,
  output logic                     busy_o
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned DATA_W = 32;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0) || (LATENCY < 1) || (LATENCY > 4) ||
      ((BASE_ADDR % (DEPTH * 4)) != 0)) begin : g_bad_params
    $error("instr_mem_pipe ID=%0d: illegal DEPTH/LATENCY/BASE_ADDR", ID);
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AW-1:0]       r_init_cnt;
  logic                w_busy;
  logic                w_run;

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                w_mem_we;
  logic [AW-1:0]       w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;

  logic                w_accept;
  logic [31:0]         w_offset;
  logic                w_in_range;
  logic [AW-1:0]       w_index;
  logic [DATA_W-1:0]   w_resp_data;
  logic                w_resp_err;

  logic                r_vld_p  [LATENCY];
  logic [DATA_W-1:0]   r_data_p [LATENCY];
  logic                r_err_p  [LATENCY];

  // FSM: state register / next-state / outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == S_INIT) && (r_init_cnt == AW'(DEPTH - 1))) begin
      w_state_nxt = S_RUN;
    end
  end

  always_comb begin
    w_busy = (r_state == S_INIT);
    w_run  = (r_state == S_RUN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_init_cnt <= '0;
    end else if (w_busy) begin
      r_init_cnt <= r_init_cnt + AW'(1);
    end
  end

  // Single write port: the fill sweep owns it during INIT, program loads afterwards.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = r_init_cnt;
    w_mem_wdata = NO_OP;
    if (w_busy) begin
      w_mem_we = 1'b1;
    end else if (load_we_i) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = load_addr_i;
      w_mem_wdata = load_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Fetch acceptance and address decode
  assign instr_gnt_o = instr_req_i & w_run & ~load_we_i;
  assign w_accept    = instr_req_i & instr_gnt_o;
  assign w_offset    = instr_addr_i - BASE_ADDR;
  assign w_index     = w_offset[AW+1:2];
  assign w_in_range  = (instr_addr_i >= BASE_ADDR) && (w_offset < DEPTH * 4) &&
                       (w_offset[1:0] == 2'b00);

  // Response is frozen at acceptance, so later loads cannot disturb it.
  always_comb begin
    w_resp_data = NO_OP;
    w_resp_err  = 1'b0;
    if (enable_i) begin
      if (w_in_range) begin
        w_resp_data = r_mem[w_index];
      end else begin
        w_resp_err = 1'b1;
      end
    end
  end

  // Stage p0: captured at the acceptance edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld_p[0] <= 1'b0;
    end else begin
      r_vld_p[0] <= w_accept;
    end
  end

  always_ff @(posedge clk_i) begin
    r_data_p[0] <= w_resp_data;
    r_err_p[0]  <= w_resp_err;
  end

  // Stages p1..p(LATENCY-1): plain delay line, one slot per in-flight response
  for (genvar g = 1; g < LATENCY; g++) begin : g_pipe
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_vld_p[g] <= 1'b0;
      end else begin
        r_vld_p[g] <= r_vld_p[g-1];
      end
    end

    always_ff @(posedge clk_i) begin
      r_data_p[g] <= r_data_p[g-1];
      r_err_p[g]  <= r_err_p[g-1];
    end
  end

  assign instr_rvalid_o = r_vld_p[LATENCY-1];
  assign instr_rdata_o  = r_vld_p[LATENCY-1] ? r_data_p[LATENCY-1] : NO_OP;
  assign instr_err_o    = r_vld_p[LATENCY-1] & r_err_p[LATENCY-1];
  assign busy_o         = w_busy;

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Randomised scoreboard bench for instr_mem_pipe with a word-array reference model.
module tb_instr_mem_pipe;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned LAT   = 3;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic          req   = 1'b0;
  logic [31:0]   addr  = '0;
  logic          we    = 1'b0;
  logic [AW-1:0] la    = '0;
  logic [31:0]   ld    = '0;
  logic          gnt, rvalid, err, busy;
  logic [31:0]   rdata;

  instr_mem_pipe #(
    .ID(7), .DEPTH(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE), .NO_OP(NOP)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt), .instr_rvalid_o(rvalid), .instr_rdata_o(rdata), .instr_err_o(err),
    .load_we_i(we), .load_addr_i(la), .load_data_i(ld), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mx;
  logic [31:0] model_mem [DEPTH];
  int          cyc;
  int          checks = 0;
  int          errors = 0;

  // Rising edges seen since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model_fetch(input logic [31:0] a, input logic e, input int due);
    exp_t        r;
    logic [31:0] off;
    r.due = due;
    r.d   = NOP;
    r.e   = 1'b0;
    if (e) begin
      off = a - BASE;
      if ((a < BASE) || (a % 4 != 0) || (off / 4 >= DEPTH)) r.e = 1'b1;
      else r.d = model_mem[int'(off / 4)];
    end
    return r;
  endfunction

  // One clock cycle of stimulus; the expected response is queued when the fetch is granted.
  task automatic step(input logic r, input logic [31:0] a, input logic e,
                      input logic w, input logic [AW-1:0] wa, input logic [31:0] wd);
    logic exp_busy, exp_gnt;
    @(posedge clk); #1;
    req = r; addr = a; en = e; we = w; la = wa; ld = wd;
    @(negedge clk);
    if (rst_n) begin
      exp_busy = (cyc < DEPTH);
      exp_gnt  = r && !exp_busy && !w;
      chk("busy", {31'b0, busy}, {31'b0, exp_busy});
      chk("gnt", {31'b0, gnt}, {31'b0, exp_gnt});
      if (exp_gnt) sb.push_back(model_fetch(a, e, cyc + LAT));
      if (w && !exp_busy) model_mem[wa] = wd;
    end
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0);
  endtask

  task automatic rand_step();
    logic        r, e, w;
    logic [31:0] a;
    int          sel;
    r   = ($urandom_range(0, 9) < 7);
    e   = ($urandom_range(0, 9) != 0);
    w   = ($urandom_range(0, 3) == 0);
    sel = $urandom_range(0, 5);
    if (sel < 4)       a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4;
    else if (sel == 4) a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
    else               a = $urandom();
    step(r, a, e, w, AW'($urandom_range(0, DEPTH - 1)), $urandom());
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk); #1;
    rst_n = 1'b0; req = 1'b1; en = 1'b1; we = 1'b0; addr = 32'h0;
    for (int i = 0; i < hold; i++) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
  endtask

  // Monitor: pops the scoreboard whenever a response is presented
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
      chk("rst_gnt", {31'b0, gnt}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd1);
      chk("rst_rdata", rdata, NOP);
      chk("rst_err", {31'b0, err}, 32'd0);
      sb.delete();
    end else if (rvalid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rdata %h, no response outstanding", rdata);
      end else begin
        mx = sb.pop_front();
        chk("rsp_cycle", cyc, mx.due);
        chk("rsp_rdata", rdata, mx.d);
        chk("rsp_err", {31'b0, err}, {31'b0, mx.e});
      end
    end else begin
      chk("idle_rdata", rdata, NOP);
      chk("idle_err", {31'b0, err}, 32'd0);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        mx = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_rvalid: rvalid 0, expected rdata %h due cycle %0d", mx.d, mx.due);
      end
    end
  end

  initial begin
    do_reset(3);
    // Fill sweep: busy for DEPTH cycles, no grant even with requests pending
    for (int i = 0; i < DEPTH + 2; i++) rand_step();

    step(1'b1, 32'h7C, 1'b1, 1'b0, '0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b1, AW'(5), 32'hDEAD_BEEF);
    step(1'b1, 32'h14, 1'b1, 1'b0, '0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b1, AW'(i), 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 3; i++) step(1'b1, 32'(i * 4), 1'b1, 1'b0, '0, 32'h0);
    step(1'b1, 32'h200, 1'b1, 1'b0, '0, 32'h0);
    step(1'b1, 32'h6, 1'b1, 1'b0, '0, 32'h0);
    step(1'b1, 32'h14, 1'b0, 1'b0, '0, 32'h0);
    step(1'b1, 32'h24, 1'b1, 1'b1, AW'(9), 32'hCAFE_F00D);
    step(1'b1, 32'h24, 1'b1, 1'b0, '0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b1, AW'(7), 32'h1234_5678);
    step(1'b1, 32'h1C, 1'b1, 1'b0, '0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b1, AW'(7), 32'h8765_4321);
    for (int i = 0; i < LAT + 2; i++) idle();

    for (int i = 0; i < 500; i++) rand_step();

    // Two fetches in flight, then reset: nothing may come back
    step(1'b1, 32'h14, 1'b1, 1'b0, '0, 32'h0);
    step(1'b1, 32'h0, 1'b1, 1'b0, '0, 32'h0);
    do_reset(2);
    for (int i = 0; i < DEPTH + 2; i++) rand_step();
    step(1'b1, 32'h14, 1'b1, 1'b0, '0, 32'h0);

    for (int i = 0; i < 200; i++) rand_step();
    for (int i = 0; i < LAT + 3; i++) idle();
    chk("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
